// File: rtl/fifo_ctrl.sv
// Pointer/handshake controller for a first-word-fall-through FIFO on an external
// simple-dual-port RAM with combinational read data.
module fifo_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [AW-1:0]         ram_write_addr,
  output logic [AW-1:0]         ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t AFULL_CNT = ptr_t'(AFULL_LEVEL);
  localparam ptr_t ONE       = ptr_t'(1);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic push, pop;

  // Extra wrap bit distinguishes full (MSBs differ) from empty (all equal).
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign s_ready     = ~full;
  assign m_valid     = ~empty;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_CNT);

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  assign ram_write      = push;
  assign ram_write_data = s_data;
  assign ram_write_addr = wr_ptr_q[AW-1:0];
  assign ram_read_addr  = rd_ptr_q[AW-1:0];
  assign m_data         = ram_read_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
